// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: stall/flush FSM states, the latch control bundle, and the
// common redirect/load-use/fetch-miss resolution used by pipeline_ctrl.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } pipe_ctrl_t;

    localparam int unsigned WAIT_CNT_W = 16;
    localparam pipe_ctrl_t  CTRL_FREEZE = '0;

    // Redirect beats load-use, which beats a fetch miss; the default is a free-running advance.
    function automatic pipe_ctrl_t resolve_hazards(input logic redirect,
                                                   input logic load_use,
                                                   input logic ihit);
        pipe_ctrl_t c;
        c = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
              ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0};
        if (redirect) begin
            c.ifid_flush  = 1'b1;
            c.idex_flush  = 1'b1;
            c.exmem_flush = 1'b1;
        end else if (load_use) begin
            c.pc_en      = 1'b0;
            c.ifid_en    = 1'b0;
            c.idex_flush = 1'b1;
        end else if (!ihit) begin
            c.pc_en      = 1'b0;
            c.ifid_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the ID/EX load and the IF/ID sources.
module load_use_detect (
    input  logic       idex_dload,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    output logic       hazard
);

    // $zero is never a real dependency.
    assign hazard = idex_dload && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with sticky halt and memory-wait watchdog.
// Optional PIPE_PERF_EN adds stall and redirect-flush event counters.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        dmem_req,
    input  logic        redirect,
    input  logic        idex_dload,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        wb_halt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        halted_o,
    output logic        err_o
`ifdef PIPE_PERF_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    pipe_state_t             state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    load_use;
    logic                    halted;
    pipe_ctrl_t              ctrl;

    load_use_detect u_load_use_detect (
        .idex_dload (idex_dload),
        .idex_rt    (idex_rt),
        .ifid_rs    (ifid_rs),
        .ifid_rt    (ifid_rt),
        .hazard     (load_use)
    );

    always_comb begin
        ctrl    = CTRL_FREEZE;
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        halted  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (wb_halt) begin
                    state_d = HALT;
                end else if (dmem_req && !dhit) begin
                    state_d = MEMWAIT;
                    cnt_d   = WAIT_CNT_W'(1);
                end else begin
                    ctrl = resolve_hazards(redirect, load_use, ihit);
                end
            end
            MEMWAIT: begin
                if (!dhit) begin
                    if (cnt_q != '1) cnt_d = cnt_q + WAIT_CNT_W'(1);
                    if (cnt_q == WAIT_CNT_W'(TIMEOUT)) err_d = 1'b1;
                end else begin
                    ctrl    = resolve_hazards(redirect, load_use, ihit);
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            HALT: halted = 1'b1;
            default: state_d = RUN;
        endcase
        // Everything reads as idle during the reset cycle.
        if (RST) begin
            ctrl   = CTRL_FREEZE;
            halted = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign ifid_en     = ctrl.ifid_en;
    assign idex_en     = ctrl.idex_en;
    assign exmem_en    = ctrl.exmem_en;
    assign memwb_en    = ctrl.memwb_en;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_flush = ctrl.exmem_flush;
    assign halted_o    = halted;
    assign err_o       = err_q && !RST;

`ifdef PIPE_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Only a redirect raises exmem_flush, so it marks a redirect that actually took effect.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (state_q != HALT) begin
            if (!ctrl.pc_en)      stall_cnt_q <= stall_cnt_q + 32'd1;
            if (ctrl.exmem_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed stimulus pushes expected outputs,
// a negedge monitor pops and compares.
module tb_pipeline_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ihit, dhit, dmem_req, redirect, idex_dload, wb_halt;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, halted_o, err_o;

    int compared   = 0;
    int mismatched = 0;

    logic [9:0] exp_q[$];
    string      name_q[$];

    // {pc_en, ifid/idex/exmem/memwb_en, ifid/idex/exmem_flush, halted_o, err_o}
    localparam logic [9:0] E_ZERO  = 10'b00000_000_00;
    localparam logic [9:0] E_RUN   = 10'b11111_000_00;
    localparam logic [9:0] E_REDIR = 10'b11111_111_00;
    localparam logic [9:0] E_LU    = 10'b00111_010_00;
    localparam logic [9:0] E_IMISS = 10'b01111_100_00;
    localparam logic [9:0] E_HALT  = 10'b00000_000_10;
    localparam logic [9:0] E_ERR   = 10'b00000_000_01;

    pipeline_ctrl #(.TIMEOUT(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .dhit        (dhit),
        .dmem_req    (dmem_req),
        .redirect    (redirect),
        .idex_dload  (idex_dload),
        .idex_rt     (idex_rt),
        .ifid_rs     (ifid_rs),
        .ifid_rt     (ifid_rt),
        .wb_halt     (wb_halt),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_flush (exmem_flush),
        .halted_o    (halted_o),
        .err_o       (err_o)
    );

    always #5 CLK = ~CLK;

    // Monitor: one output vector per cycle, sampled mid-cycle.
    initial begin
        logic [9:0] act, exp;
        string      nm;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                       ifid_flush, idex_flush, exmem_flush, halted_o, err_o};
                compared++;
                if (act !== exp) begin
                    mismatched++;
                    $display("FAIL %s: got %b expected %b", nm, act, exp);
                end
            end
        end
    end

    task automatic drive(input logic rst, input logic ih, input logic dh, input logic dreq,
                         input logic redir, input logic dload, input logic [4:0] ert,
                         input logic [4:0] rs, input logic [4:0] rt, input logic halt);
        RST = rst; ihit = ih; dhit = dh; dmem_req = dreq; redirect = redir;
        idex_dload = dload; idex_rt = ert; ifid_rs = rs; ifid_rt = rt; wb_halt = halt;
    endtask

    task automatic expect_cycle(input logic [9:0] exp, input string nm);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge CLK);
        #1;
    endtask

    // Plain running cycle: only ihit set.
    task automatic idle(input logic [9:0] exp, input string nm);
        drive(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        expect_cycle(exp, nm);
    endtask

    initial begin
        drive(1, 1, 1, 1, 1, 1, 5'd31, 5'd31, 5'd31, 1);
        @(posedge CLK);
        #1;

        // Reset with every input high
        expect_cycle(E_ZERO, "reset0");
        expect_cycle(E_ZERO, "reset1");
        idle(E_RUN, "first_run");

        // Load-use and fetch miss
        drive(0, 1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd3, 0);   expect_cycle(E_LU, "lu_rs");
        drive(0, 1, 0, 0, 0, 0, 5'd5, 5'd5, 5'd3, 0);   expect_cycle(E_RUN, "lu_release");
        drive(0, 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);   expect_cycle(E_RUN, "lu_rt_zero");
        drive(0, 0, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0);   expect_cycle(E_LU, "lu_rt_over_imiss");
        drive(0, 1, 0, 0, 0, 1, 5'd7, 5'd6, 5'd8, 0);   expect_cycle(E_RUN, "lu_no_match");
        drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);   expect_cycle(E_IMISS, "imiss");
        drive(0, 0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd5, 0);   expect_cycle(E_REDIR, "redirect_collide");
        drive(0, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);   expect_cycle(E_RUN, "dmem_hit_no_freeze");

        // Data wait for three frozen cycles
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
            expect_cycle(E_ZERO, "memwait_freeze");
        end
        drive(0, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);   expect_cycle(E_RUN, "memwait_dhit");
        drive(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);   expect_cycle(E_RUN, "back_in_run");

        // Redirect resolved on the cycle the wait ends
        drive(0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);   expect_cycle(E_ZERO, "memwait_enter");
        drive(0, 0, 1, 1, 1, 1, 5'd4, 5'd4, 5'd0, 0);   expect_cycle(E_REDIR, "memwait_dhit_redir");
        drive(0, 1, 1, 1, 0, 1, 5'd9, 5'd0, 5'd9, 0);   expect_cycle(E_LU, "run_after_redir_lu");

        // Watchdog: counter 1..4 frozen without error, error visible on the next cycle
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
            expect_cycle(E_ZERO, "wdog_count");
        end
        drive(0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);   expect_cycle(E_ERR, "wdog_err");
        drive(0, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);   expect_cycle(E_RUN | E_ERR, "wdog_dhit");
        idle(E_RUN | E_ERR, "wdog_sticky");
        drive(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);   expect_cycle(E_ZERO, "wdog_reset");
        idle(E_RUN, "wdog_cleared");

        // Halt is sticky until reset
        drive(0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1);   expect_cycle(E_ZERO, "halt_enter");
        drive(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);   expect_cycle(E_HALT, "halt_redir");
        drive(0, 1, 1, 1, 0, 1, 5'd2, 5'd2, 5'd0, 0);   expect_cycle(E_HALT, "halt_ihit");
        drive(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);   expect_cycle(E_HALT, "halt_dwait");
        drive(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);   expect_cycle(E_ZERO, "halt_reset");
        idle(E_RUN, "halt_released");

        // Halt outranks a data-memory freeze
        drive(0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 1);   expect_cycle(E_ZERO, "halt_over_dwait");
        drive(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);   expect_cycle(E_HALT, "halt_not_memwait");
        drive(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);   expect_cycle(E_ZERO, "final_reset");
        idle(E_RUN, "final_run");

        repeat (3) @(negedge CLK);
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
